// File: rtl/car_dash_pkg.sv
// Shared definitions for the Car_Dash game datapath.
//   - move_result encodings produced by the move/immunity evaluation stage
//   - default lane count
//   - lane tracker FSM state type
package car_dash_pkg;

  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;  // position + 1
  localparam logic [1:0] MOVE_RIGHT = 2'b01;  // position - 1
  localparam logic [1:0] MOVE_CRASH = 2'b11;

  localparam int unsigned LANES = 6;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StOver
  } car_state_e;

endpackage

// File: rtl/car_tick_timer.sv
// Game tick pacing counter.
// Counts enabled cycles and raises a one-cycle registered eval strobe every TICK_CYCLES of them.
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   enable_i   count this cycle
//   restart_i  hold the counter at zero (takes priority over enable_i)
//   tick_o     combinational: this edge wraps the counter
//   eval_o     registered strobe, high in the cycle after a wrap edge
module car_tick_timer #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o,
  output logic eval_o
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            eval_q, eval_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign eval_d = tick_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      eval_q <= eval_d;
    end
  end

  assign eval_o = eval_q;

endmodule

// File: rtl/car_lane_tracker.sv
// Car_Dash lane tracker: paces game ticks, requests one move evaluation per tick, waits
// RESULT_LAT cycles, then commits move_result to lane position, lives and (optionally) score.
// Build option: define CAR_SCORE_EN to include the saturating score counter and score port.
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   enable       advance the tick counter while high
//   move_result  evaluation result: 00 none, 10 left (+1), 01 right (-1), 11 crash
//   eval         one-cycle strobe to the evaluation stage
//   position     current lane, zero-extended
//   lives        remaining lives
//   crash        one-cycle pulse on a committed crash
//   game_over    sticky, set when lives reach zero
//   score        committed safe ticks, saturating (CAR_SCORE_EN only)
module car_lane_tracker import car_dash_pkg::*; #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned RESULT_LAT  = 2,
  parameter int unsigned LANES       = car_dash_pkg::LANES,
  parameter int unsigned START_POS   = 2,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] move_result,
  output logic       eval,
  output logic [5:0] position,
  output logic [2:0] lives,
  output logic       crash,
  output logic       game_over
`ifdef CAR_SCORE_EN
  ,
  output logic [SCORE_W-1:0] score
`endif
);

  localparam int unsigned LatW = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;
  localparam logic [5:0] PosMax = 6'(LANES - 1);

  if (TICK_CYCLES < RESULT_LAT + 2) begin : g_chk_tick
    $error("TICK_CYCLES must be at least RESULT_LAT + 2");
  end
  if (LANES < 1 || LANES > 64 || START_POS >= LANES) begin : g_chk_lanes
    $error("LANES must be 1..64 and START_POS below LANES");
  end
  if (START_LIVES < 1 || START_LIVES > 7 || SCORE_W < 1) begin : g_chk_lives
    $error("START_LIVES must be 1..7 and SCORE_W at least 1");
  end

  car_state_e      state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [5:0]      pos_q, pos_d;
  logic [2:0]      lives_q, lives_d;
  logic            crash_q, crash_d;
  logic            over_q, over_d;
  logic            tick;
`ifdef CAR_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
`endif

  // The counter is parked at zero outside RUN so the next tick is measured from the commit.
  car_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_timer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .enable_i (enable),
    .restart_i(state_q != StRun),
    .tick_o   (tick),
    .eval_o   (eval)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pos_d   = pos_q;
    lives_d = lives_q;
    crash_d = 1'b0;
    over_d  = over_q;
`ifdef CAR_SCORE_EN
    score_d = score_q;
`endif
    unique case (state_q)
      StRun: begin
        if (tick) begin
          state_d = StWait;
          lat_d   = LatW'(RESULT_LAT);
        end
      end
      StWait: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          state_d = StRun;
          unique case (move_result)
            MOVE_LEFT:  if (pos_q < PosMax) pos_d = pos_q + 1'b1;
            MOVE_RIGHT: if (pos_q != '0) pos_d = pos_q - 1'b1;
            MOVE_CRASH: begin
              crash_d = 1'b1;
              if (lives_q != '0) lives_d = lives_q - 1'b1;
              if (lives_q <= 3'd1) begin
                over_d  = 1'b1;
                state_d = StOver;
              end
            end
            default: ;
          endcase
`ifdef CAR_SCORE_EN
          if (move_result != MOVE_CRASH && score_q != '1) score_d = score_q + 1'b1;
`endif
        end
      end
      StOver: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StRun;
      lat_q   <= '0;
      pos_q   <= 6'(START_POS);
      lives_q <= 3'(START_LIVES);
      crash_q <= 1'b0;
      over_q  <= 1'b0;
`ifdef CAR_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      pos_q   <= pos_d;
      lives_q <= lives_d;
      crash_q <= crash_d;
      over_q  <= over_d;
`ifdef CAR_SCORE_EN
      score_q <= score_d;
`endif
    end
  end

  assign position  = pos_q;
  assign lives     = lives_q;
  assign crash     = crash_q;
  assign game_over = over_q;
`ifdef CAR_SCORE_EN
  assign score     = score_q;
`endif

endmodule
